// File: rtl/id_stage_pipelined.sv
// Pipelined instruction-decode stage: register file with write-back bypass, control/immediate
// decode, load-use stall and an ID/EX output register with valid/ready handshake and flush.
module id_stage_pipelined #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [WIDTH-1:0]      in_pc,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_pc,
    output logic [WIDTH-1:0]      out_rs1_data,
    output logic [WIDTH-1:0]      out_rs2_data,
    output logic [WIDTH-1:0]      out_imm,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [3:0]            out_alu_ctrl,
    output logic                  out_alu_src,
    output logic                  out_branch,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic                  out_reg_write,
    output logic [2:0]            out_mem_ctrl,
    output logic                  out_illegal
);

    localparam int NumRegs = 2 ** REG_ADDR_W;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOr    = 4'b0001;
    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluXor   = 4'b0011;
    localparam logic [3:0] AluSll   = 4'b0100;
    localparam logic [3:0] AluSrl   = 4'b0101;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluSlt   = 4'b0111;
    localparam logic [3:0] AluSltu  = 4'b1000;
    localparam logic [3:0] AluSra   = 4'b1001;
    localparam logic [3:0] AluPassB = 4'b1010;

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? AluSub : AluAdd;
            3'b001:  code = AluSll;
            3'b010:  code = AluSlt;
            3'b011:  code = AluSltu;
            3'b100:  code = AluXor;
            3'b101:  code = alt ? AluSra : AluSrl;
            3'b110:  code = AluOr;
            default: code = AluAnd;
        endcase
        return code;
    endfunction

    logic [WIDTH-1:0]      regs_q [NumRegs];
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic [WIDTH-1:0]      rs1_data, rs2_data;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign rd     = REG_ADDR_W'(in_instr[11:7]);
    assign rs1    = REG_ADDR_W'(in_instr[19:15]);
    assign rs2    = REG_ADDR_W'(in_instr[24:20]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && wb_rd != '0) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Write-first bypass so an instruction decoded in the WB cycle sees the new value.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != '0) begin
            rs1_data = (wb_en && wb_rd == rs1) ? wb_data : regs_q[rs1];
        end
        if (rs2 != '0) begin
            rs2_data = (wb_en && wb_rd == rs2) ? wb_data : regs_q[rs2];
        end
    end

    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic signed [31:0] imm32;
    logic [3:0]         alu_ctrl;
    logic               alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write;
    logic [2:0]         mem_ctrl;
    logic               illegal, uses_rs1, uses_rs2;

    always_comb begin
        imm32      = '0;
        alu_ctrl   = AluAnd;
        alu_src    = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_ctrl   = 3'b000;
        illegal    = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (opcode)
            OpR: begin
                alu_ctrl  = alu_from_funct3(funct3, in_instr[30]);
                reg_write = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OpImm: begin
                // Bit 30 is part of the immediate except for the shift-right pair.
                alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && in_instr[30]);
                imm32     = imm_i;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                uses_rs1  = 1'b1;
            end
            OpLoad: begin
                alu_ctrl   = AluAdd;
                imm32      = imm_i;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_ctrl   = funct3;
                uses_rs1   = 1'b1;
            end
            OpStore: begin
                alu_ctrl  = AluAdd;
                imm32     = imm_s;
                alu_src   = 1'b1;
                mem_write = 1'b1;
                mem_ctrl  = funct3;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OpBranch: begin
                alu_ctrl = AluSub;
                imm32    = imm_b;
                branch   = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OpLui: begin
                alu_ctrl  = AluPassB;
                imm32     = imm_u;
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OpAuipc: begin
                alu_ctrl  = AluAdd;
                imm32     = imm_u;
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OpJal: begin
                alu_ctrl  = AluAdd;
                imm32     = imm_j;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                branch    = 1'b1;
            end
            OpJalr: begin
                alu_ctrl  = AluAdd;
                imm32     = imm_i;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                branch    = 1'b1;
                uses_rs1  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    logic hazard;
    assign hazard = out_valid && out_mem_read && (out_rd != '0) && in_valid &&
                    ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd));

    // Flush forces ready so IF drops its word in the same cycle.
    assign in_ready = flush || ((!out_valid || out_ready) && !hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_rs1_data   <= '0;
            out_rs2_data   <= '0;
            out_imm        <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_alu_ctrl   <= '0;
            out_alu_src    <= 1'b0;
            out_branch     <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_ctrl   <= '0;
            out_illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid      <= 1'b1;
            out_pc         <= in_pc;
            out_rs1_data   <= rs1_data;
            out_rs2_data   <= rs2_data;
            out_imm        <= WIDTH'(imm32);
            out_rs1        <= rs1;
            out_rs2        <= rs2;
            out_rd         <= rd;
            out_alu_ctrl   <= alu_ctrl;
            out_alu_src    <= alu_src;
            out_branch     <= branch;
            out_mem_read   <= mem_read;
            out_mem_write  <= mem_write;
            out_mem_to_reg <= mem_to_reg;
            out_reg_write  <= reg_write;
            out_mem_ctrl   <= mem_ctrl;
            out_illegal    <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: directed instructions push hand-computed ID/EX
// records; a negedge monitor pops and compares each record EX consumes.
module tb_id_stage_pipelined;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [3:0]  out_alu_ctrl;
    logic        out_alu_src, out_branch, out_mem_read, out_mem_write, out_mem_to_reg;
    logic        out_reg_write, out_illegal;
    logic [2:0]  out_mem_ctrl;

    id_stage_pipelined #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_alu_ctrl(out_alu_ctrl),
        .out_alu_src(out_alu_src), .out_branch(out_branch), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_reg_write(out_reg_write), .out_mem_ctrl(out_mem_ctrl), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [5:0]  ctl;
        logic [2:0]  mem_ctrl;
        logic        illegal;
    } rec_t;

    rec_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] imm,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic [3:0] alu, input logic [5:0] ctl,
                                input logic [2:0] mc, input logic ill);
        rec_t r;
        r.pc = pc; r.rs1_data = d1; r.rs2_data = d2; r.imm = imm;
        r.rs1 = r1; r.rs2 = r2; r.rd = rd; r.alu = alu; r.ctl = ctl;
        r.mem_ctrl = mc; r.illegal = ill;
        return r;
    endfunction

    function automatic rec_t cur_out();
        return mk(out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd,
                  out_alu_ctrl, {out_alu_src, out_branch, out_mem_read, out_mem_write,
                  out_mem_to_reg, out_reg_write}, out_mem_ctrl, out_illegal);
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h expected=none", cur_out());
            end else begin
                check(name_q.pop_front(), 160'(cur_out()), 160'(exp_q.pop_front()));
            end
        end
    end

    // Present an instruction until accepted; reports stall cycles and out_valid at acceptance.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input rec_t e,
                         input string name, input bit push, output int stalls,
                         output logic ov_acc);
        bit acc = 0;
        stalls = 0;
        ov_acc = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc = pc;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                ov_acc = out_valid;
                if (push) begin
                    exp_q.push_back(e);
                    name_q.push_back(name);
                end
            end else begin
                stalls++;
            end
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL %s_accept actual=timeout expected=accepted", name);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
        wb_en = 1'b1;
        wb_rd = rd;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    int   st;
    logic ova;
    rec_t snap;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        #2;
        check("reset_out_valid", 160'(out_valid), 160'(0));
        check("reset_in_ready", 160'(in_ready), 160'(1));
        check("reset_outputs", 160'(cur_out()), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        wb_write(5'd1, 32'h0000_2000);
        wb_write(5'd2, 32'h0000_0077);
        wb_write(5'd5, 32'h0000_0055);
        wb_write(5'd6, 32'h0000_1000);

        // add x1,x3,x0 decoded in the same cycle WB writes x3
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        issue({7'd0, 5'd0, 5'd3, 3'b000, 5'd1, 7'b0110011}, 32'h100,
              mk(32'h100, 32'hDEAD_BEEF, 0, 0, 5'd3, 5'd0, 5'd1, 4'b0010, 6'b000001, 3'd0, 0),
              "add_bypass", 1, st, ova);
        wb_en = 1'b0;
        check("bypass_stalls", 160'(st), 160'(0));

        // lw x2,-4(x1) then add x4,x2,x2: one-cycle load-use bubble
        issue({12'hFFC, 5'd1, 3'b010, 5'd2, 7'b0000011}, 32'h104,
              mk(32'h104, 32'h2000, 0, 32'hFFFF_FFFC, 5'd1, 5'd28, 5'd2, 4'b0010, 6'b101011,
                 3'b010, 0), "lw", 1, st, ova);
        issue({7'd0, 5'd2, 5'd2, 3'b000, 5'd4, 7'b0110011}, 32'h108,
              mk(32'h108, 32'h77, 32'h77, 0, 5'd2, 5'd2, 5'd4, 4'b0010, 6'b000001, 3'd0, 0),
              "add_after_lw", 1, st, ova);
        check("load_use_stalls", 160'(st), 160'(1));
        check("load_use_bubble", 160'(ova), 160'(0));

        // EX back-pressure for 3 cycles while sub x9,x6,x5 waits
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = {7'b0100000, 5'd5, 5'd6, 3'b000, 5'd9, 7'b0110011};
        in_pc = 32'h10C;
        snap = cur_out();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready", 160'(in_ready), 160'(0));
            check("hold_stable", 160'(cur_out()), 160'(snap));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue({7'b0100000, 5'd5, 5'd6, 3'b000, 5'd9, 7'b0110011}, 32'h10C,
              mk(32'h10C, 32'h1000, 32'h55, 0, 5'd6, 5'd5, 5'd9, 4'b0110, 6'b000001, 3'd0, 0),
              "sub_after_hold", 1, st, ova);
        check("release_stalls", 160'(st), 160'(0));

        issue({7'b0100000, 5'd4, 5'd6, 3'b101, 5'd10, 7'b0010011}, 32'h110,
              mk(32'h110, 32'h1000, 0, 32'h404, 5'd6, 5'd4, 5'd10, 4'b1001, 6'b100001, 3'd0, 0),
              "srai", 1, st, ova);
        issue({7'b0100000, 5'd0, 5'd5, 3'b000, 5'd11, 7'b0010011}, 32'h114,
              mk(32'h114, 32'h55, 0, 32'h400, 5'd5, 5'd0, 5'd11, 4'b0010, 6'b100001, 3'd0, 0),
              "addi_bit30", 1, st, ova);
        issue({7'h7F, 5'd5, 5'd6, 3'b010, 5'b11000, 7'b0100011}, 32'h118,
              mk(32'h118, 32'h1000, 32'h55, 32'hFFFF_FFF8, 5'd6, 5'd5, 5'd24, 4'b0010,
                 6'b100100, 3'b010, 0), "sw", 1, st, ova);
        issue({1'b1, 10'd0, 1'b1, 8'hFF, 5'd1, 7'b1101111}, 32'h11C,
              mk(32'h11C, 0, 32'h2000, 32'hFFFF_F800, 5'd31, 5'd1, 5'd1, 4'b0010, 6'b110001,
                 3'd0, 0), "jal", 1, st, ova);
        issue({20'h12345, 5'd7, 7'b0110111}, 32'h120,
              mk(32'h120, 0, 32'hDEAD_BEEF, 32'h1234_5000, 5'd8, 5'd3, 5'd7, 4'b1010,
                 6'b100001, 3'd0, 0), "lui", 1, st, ova);
        issue({1'b0, 6'd0, 5'd6, 5'd5, 3'b000, 4'b1000, 1'b0, 7'b1100011}, 32'h124,
              mk(32'h124, 32'h55, 32'h1000, 32'h10, 5'd5, 5'd6, 5'd16, 4'b0110, 6'b010000,
                 3'd0, 0), "beq", 1, st, ova);
        issue(32'h0000_007F, 32'h128,
              mk(32'h128, 0, 0, 0, 5'd0, 5'd0, 5'd0, 4'b0000, 6'b000000, 3'd0, 1),
              "illegal", 1, st, ova);

        // Flush kills both the held and the incoming instruction
        drain();
        out_ready = 1'b0;
        issue({7'd0, 5'd2, 5'd2, 3'b000, 5'd4, 7'b0110011}, 32'h200, '0, "flushed", 0, st, ova);
        in_valid = 1'b1;
        in_instr = {12'h001, 5'd5, 3'b000, 5'd14, 7'b0010011};
        in_pc = 32'h204;
        flush = 1'b1;
        @(negedge clk);
        check("flush_pre_valid", 160'(out_valid), 160'(1));
        check("flush_in_ready", 160'(in_ready), 160'(1));
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 160'(out_valid), 160'(0));
        out_ready = 1'b1;

        // Writes to x0 are ignored, including the bypass path
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        issue({7'd0, 5'd0, 5'd0, 3'b000, 5'd12, 7'b0110011}, 32'h130,
              mk(32'h130, 0, 0, 0, 5'd0, 5'd0, 5'd12, 4'b0010, 6'b000001, 3'd0, 0),
              "x0_bypass", 1, st, ova);
        wb_en = 1'b0;
        issue({7'd0, 5'd0, 5'd0, 3'b000, 5'd12, 7'b0110011}, 32'h134,
              mk(32'h134, 0, 0, 0, 5'd0, 5'd0, 5'd12, 4'b0010, 6'b000001, 3'd0, 0),
              "x0_read", 1, st, ova);

        // Asynchronous reset with an instruction held in ID/EX
        drain();
        out_ready = 1'b0;
        issue({7'd0, 5'd2, 5'd2, 3'b000, 5'd4, 7'b0110011}, 32'h300, '0, "pre_reset", 0, st, ova);
        check("pre_reset_valid", 160'(out_valid), 160'(1));
        rst = 1'b1;
        #1;
        check("async_reset_valid", 160'(out_valid), 160'(0));
        check("async_reset_outputs", 160'(cur_out()), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        issue({7'd0, 5'd0, 5'd5, 3'b000, 5'd13, 7'b0110011}, 32'h138,
              mk(32'h138, 0, 0, 0, 5'd5, 5'd0, 5'd13, 4'b0010, 6'b000001, 3'd0, 0),
              "x5_after_reset", 1, st, ova);

        drain();
        check("scoreboard_empty", 160'(exp_q.size()), 160'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised instruction-decode stage: opcode decode, register file, immediate generation, ALU-control and memory-control derivation.
- Adds an ID/EX output register with valid/ready handshake, write-back bypass, load-use stall and flush.
- Sits between the IF stage (instruction/PC producer) and the EX stage; WB feeds its register-write port.

Parameters:
WIDTH, 32, datapath/register/immediate/PC width
REG_ADDR_W, 5, register address width; register count = 2**REG_ADDR_W; x0 hardwired to 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  IF presents an instruction
in_ready  out  1  stage accepts it this cycle
in_instr  in  32  instruction word
in_pc  in  WIDTH  instruction PC
wb_en  in  1  register write enable from WB
wb_rd  in  REG_ADDR_W  write address
wb_data  in  WIDTH  write data
flush  in  1  kill held and incoming instruction (branch redirect)
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX accepts it
out_pc  out  WIDTH  PC
out_rs1_data, out_rs2_data  out  WIDTH each  operands
out_imm  out  WIDTH  sign-extended immediate
out_rs1, out_rs2, out_rd  out  REG_ADDR_W each  register addresses
out_alu_ctrl  out  4  ALU operation
out_alu_src  out  1  1 = immediate operand B
out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write  out  1 each  control bits
out_mem_ctrl  out  3  load/store size/sign, equals funct3 for LOAD/STORE, else 0
out_illegal  out  1  unrecognised opcode

Behaviour:
- Reset (async): all registers x1..xN = 0; every out_* = 0; in_ready follows its combinational equation (1 after reset).
- Register file: writes on rising clk when wb_en && wb_rd != 0. Reads are combinational with write-first bypass: if wb_en && wb_rd == rs && rs != 0, read value = wb_data. x0 always reads 0.
- Decode by opcode (others 0):
  - R 0110011: reg_write.
  - I-ALU 0010011: alu_src, reg_write.
  - LOAD 0000011: alu_src, mem_read, mem_to_reg, reg_write; ALU = ADD.
  - STORE 0100011: alu_src, mem_write; ALU = ADD.
  - BRANCH 1100011: branch; ALU = SUB.
  - LUI 0110111: alu_src, reg_write; ALU = PASS_B.
  - AUIPC 0010111, JAL 1101111, JALR 1100111: reg_write, alu_src; ALU = ADD; JAL/JALR also set branch.
  - Any other opcode: all controls 0, out_illegal = 1; the instruction still flows.
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1001, PASS_B 1010.
  - R-type: funct3 with instr[30] selects SUB/SRA.
  - I-ALU: instr[30] is honoured only for funct3 = 101.
- Immediates:
  - I: instr[31:20].
  - S: {31:25, 11:7}.
  - B: {31, 7, 30:25, 11:8, 0}.
  - U: {31:12, 12'b0}.
  - J: {31, 19:12, 20, 30:21, 0}.
  - All sign-extended to WIDTH.
- Load-use hazard: hazard = out_valid && out_mem_read && out_rd != 0 && in_valid && ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd)).
  - uses_rs1: all formats except LUI, AUIPC, JAL.
  - uses_rs2: R, STORE, BRANCH.
- Handshake: in_ready = (!out_valid || out_ready) && !hazard.
  - On clk: if in_valid && in_ready, load the ID/EX register (latency 1 cycle); out_valid = 1.
  - Else if out_ready, out_valid = 0 (bubble); other fields may hold.
  - Holding: while out_valid && !out_ready, all out_* remain stable.
  - Hazard with out_ready = 1: load leaves, a bubble is inserted, and the dependent instruction is accepted next cycle.
- flush (highest priority): on clk, out_valid = 0 and the incoming instruction is dropped. in_ready = 1 during flush so IF discards its word.
- Simultaneous WB write and decode read of the same register: the bypassed value is captured.

Test Plan:
- Reset mid-stream with out_valid = 1 -> out_valid = 0, all out_* = 0 immediately; reading x5 afterwards returns 0.
- WB wb_en = 1, wb_rd = 3, wb_data = 0xDEADBEEF, same cycle in_instr = add x1,x3,x0 -> next cycle out_rs1_data = 0xDEADBEEF, out_alu_ctrl = 0010, out_reg_write = 1.
- lw x2,-4(x1) accepted, then add x4,x2,x2 with out_ready = 1 -> in_ready = 0 one cycle, bubble (out_valid = 0), add issued the following cycle.
- out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, out_* stable; release -> queued instruction appears next cycle, no loss or duplication.
- Immediates: sw x5,-8(x6) -> out_imm = 0xFFFFFFF8, out_mem_write = 1, out_mem_ctrl = 010; jal x1,-2048 -> out_imm = 0xFFFFF800; lui x7,0x12345 -> out_imm = 0x12345000, ALU = 1010.
- flush = 1 while in_valid = 1 and out_valid = 1 -> next cycle out_valid = 0; opcode 1111111 -> out_illegal = 1, all control bits 0; write to x0 -> x0 still reads 0.
